// File: rtl/conv1x1_pkg.sv
// Shared constants, column-select codes and FSM encoding for the conv1x1 write path.
package conv1x1_pkg;

    localparam int unsigned COL_26 = 26;
    localparam int unsigned COL_13 = 13;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned SEL_W  = 3;

    // Code 4 selects the wide (26 column) feature map; every other code means 13 columns.
    localparam logic [SEL_W-1:0] SEL_COL_26 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_COL_13 = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last column index for a given column-select code.
    function automatic logic [COL_W-1:0] cols_m1(input logic [SEL_W-1:0] sel);
        return (sel == SEL_COL_26) ? COL_W'(COL_26 - 1) : COL_W'(COL_13 - 1);
    endfunction

endpackage

// File: rtl/conv1x1_write_ctrl_if.sv
// Result-beat input and output-buffer write port of the conv1x1 write controller.
interface conv1x1_write_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 12
);
    logic                    result_vld;
    logic [LANES*DATA_W-1:0] result_data;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LANES*DATA_W-1:0] wr_data;

    // Producer side: MAC pipeline drives beats, buffer writes are observed.
    modport master (
        output result_vld, result_data,
        input  wr_en, wr_addr, wr_data
    );

    // Controller side: consumes beats, drives the buffer write port.
    modport slave (
        input  result_vld, result_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv1x1_wr_addr_gen.sv
// Row/column counters and incrementing output-buffer address for one layer.
module conv1x1_wr_addr_gen
    import conv1x1_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [COL_W-1:0]  cols_m1,
    input  logic [ROW_W-1:0]  last_row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] addr_q;

    // Raster walk: column wraps and row steps on the same beat; address simply counts beats.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (clr) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (adv) begin
            if (col_q == cols_m1) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign addr   = addr_q;
    assign last_c = (row_q == last_row) && (col_q == cols_m1);

endmodule

// File: rtl/conv1x1_write_ctrl.sv
// Writes conv1x1 result beats into the output buffer in raster order, one layer per start pulse.
module conv1x1_write_ctrl
    import conv1x1_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                    sclk,
    input  logic                    s_rst,
    input  logic                    conv1x1_start,
    input  logic [SEL_W-1:0]        feature_col_select,
    input  logic [ROW_W-1:0]        feature_row,
    conv1x1_write_ctrl_if.slave     bus,
    output logic                    busy,
    output logic                    conv1x1_write_finish,
    output logic                    err_overflow
);

    localparam int unsigned PAY_W = LANES * DATA_W;

    state_t            state_q, state_d;
    logic              accept_c, clr_c, err_set_c;
    logic [COL_W-1:0]  cols_m1_q;
    logic [ROW_W-1:0]  last_row_q;
    logic [ADDR_W-1:0] beat_addr;
    logic              last_c;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PAY_W-1:0]  wr_data_q;
    logic              busy_q, finish_q, err_q;

    // FSM state register.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, beat acceptance and overflow detection.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        clr_c     = 1'b0;
        err_set_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (conv1x1_start) begin
                    state_d = ST_RUN;
                    clr_c   = 1'b1;
                end else if (bus.result_vld) begin
                    err_set_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.result_vld) begin
                    accept_c = 1'b1;
                    if (last_c) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                err_set_c = bus.result_vld;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Layer geometry captured at start so mid-layer input changes are ignored.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            cols_m1_q  <= '0;
            last_row_q <= '0;
        end else if (clr_c) begin
            cols_m1_q  <= cols_m1(feature_col_select);
            last_row_q <= feature_row;
        end
    end

    conv1x1_wr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .clr      (clr_c),
        .adv      (accept_c),
        .cols_m1  (cols_m1_q),
        .last_row (last_row_q),
        .addr     (beat_addr),
        .last_c   (last_c)
    );

    // Registered write port and status; finish lines up with the final write.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q  <= accept_c;
            busy_q   <= (state_d != ST_IDLE);
            finish_q <= (state_d == ST_DONE);
            if (accept_c) begin
                wr_addr_q <= beat_addr;
                wr_data_q <= bus.result_data;
            end
            if (clr_c)          err_q <= 1'b0;
            else if (err_set_c) err_q <= 1'b1;
        end
    end

    assign bus.wr_en            = wr_en_q;
    assign bus.wr_addr          = wr_addr_q;
    assign bus.wr_data          = wr_data_q;
    assign busy                 = busy_q;
    assign conv1x1_write_finish = finish_q;
    assign err_overflow         = err_q;

endmodule

// File: doc/conv1x1_write_ctrl.md
CONV1X1_WRITE_CTRL -- requirements
Module: conv1x1_write_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per output channel lane.
REQ-002 SHALL have parameter LANES, default 8, meaning output channels written per beat.
REQ-003 SHALL have parameter ADDR_W, default 12, meaning output buffer word-address width.
REQ-004 SHALL have port sclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port s_rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port conv1x1_start, input, 1, one-cycle layer start pulse, shared with the read controller.
REQ-007 SHALL have port feature_col_select, input, 3, column-mode select: 4 -> 26 cols; any other value -> 13 cols.
REQ-008 SHALL have port feature_row, input, 7, last row index, so row count = feature_row+1.
REQ-009 SHALL have port result_vld, input, 1, result beat valid from the conv1x1 MAC/quantise pipeline.
REQ-010 SHALL have port result_data, input, LANES*DATA_W, result beat payload.
REQ-011 SHALL have port wr_en, output, 1, output buffer write strobe.
REQ-012 SHALL have port wr_addr, output, ADDR_W, output buffer word address.
REQ-013 SHALL have port wr_data, output, LANES*DATA_W, output buffer write data.
REQ-014 SHALL have port busy, output, 1, high while a layer is in progress.
REQ-015 SHALL have port conv1x1_write_finish, output, 1, one-cycle pulse after the last beat of a layer is written.
REQ-016 SHALL have port err_overflow, output, 1, sticky flag for unexpected result beats.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE->RUN SHALL occur on conv1x1_start; RUN->DONE on acceptance of the last beat; DONE->IDLE unconditionally after 1 cycle.
REQ-019 On start, feature_col_select and feature_row SHALL be latched; input changes during RUN SHALL have no effect.
REQ-020 col_cnt SHALL run 0..COLS-1 and row_cnt 0..feature_row; both increment only on an accepted beat; col wraps to 0 and row increments on the same edge.
REQ-021 A beat is accepted when result_vld=1 in RUN.
REQ-022 Each accepted beat SHALL produce wr_en=1, wr_data=result_data and wr_addr=row_cnt*COLS+col_cnt one cycle later (latency 1, registered outputs).
REQ-023 wr_addr SHALL be produced by an incrementing address register (no multiplier), reset to 0 on start.
REQ-024 Last beat is row_cnt==feature_row and col_cnt==COLS-1; acceptance of it SHALL move the FSM to DONE.
REQ-025 conv1x1_write_finish SHALL be high in DONE, i.e. in the same cycle as the last wr_en.
REQ-026 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-027 conv1x1_start in RUN or DONE SHALL be ignored.
REQ-028 result_vld in IDLE or DONE SHALL be dropped (no write) and SHALL set err_overflow.
REQ-029 err_overflow SHALL stay set until the next accepted conv1x1_start, which clears it.
REQ-030 Simultaneous start and result_vld in IDLE SHALL enter RUN, drop the beat and set no error.
REQ-031 Gaps in result_vld SHALL be tolerated: counters and address hold between beats.

Reset
REQ-032 While s_rst=1, the block SHALL be in IDLE, all counters and wr_addr SHALL be 0, and wr_en, busy, conv1x1_write_finish and err_overflow SHALL be 0; wr_data SHALL be 0.
REQ-033 Reset asserted mid-RUN SHALL abort the layer immediately with no finish pulse.

Structure
REQ-034 Shared package conv1x1_pkg SHALL hold COL_26=26, COL_13=13, the column-select codes and the FSM state encoding.
REQ-035 Sub-module conv1x1_wr_addr_gen SHALL contain the row/column counters and the address register; the FSM and output registers stay at top level.

Verification
REQ-036 sel=5, feature_row=1, 26 continuous beats -> addresses 0..25 written, finish pulse with addr 25, busy low the next cycle.
REQ-037 sel=4, feature_row=0, beats with 1-cycle gaps -> addresses 0..25 with no skips or repeats, exactly one finish pulse.
REQ-038 result_vld while IDLE -> no wr_en and err_overflow=1; the next start clears it.
REQ-039 Start pulse mid-RUN and a change of feature_row mid-RUN -> the layer completes with the original count.
REQ-040 s_rst asserted after beat 10 of 26 -> outputs zero immediately, no finish; a new start restarts at addr 0.
REQ-041 Extra beat in DONE -> dropped and err_overflow=1.
